// File: rtl/gb_trace_pkg.sv
// gb_trace_pkg: shared types and default sizes for the GameBoy execution-trace recorder
package gb_trace_pkg;
    localparam int TRACE_ADDR_W  = 16;
    localparam int TRACE_IR_W    = 8;
    localparam int TRACE_STATE_W = 6;
    localparam int TRACE_DEPTH   = 64;
    localparam int TRACE_NUM_BP  = 4;
    localparam int TRACE_ENTRY_W = TRACE_ADDR_W + TRACE_IR_W + TRACE_STATE_W;
    typedef struct packed {
        logic [TRACE_ADDR_W-1:0]  pc;
        logic [TRACE_IR_W-1:0]    ir;
        logic [TRACE_STATE_W-1:0] cp_state;
    } trace_entry_t;
    typedef enum logic [1:0] {IDLE, ARMED, POST, FROZEN} trace_state_e;
endpackage

// File: rtl/gb_trace_ram.sv
// gb_trace_ram: DEPTH x W trace storage with one write port and one registered read port
module gb_trace_ram #(
    parameter int W     = 30,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/gb_trace_buffer.sv
// gb_trace_buffer: circular instruction-trace recorder with PC breakpoints, trigger-and-freeze and indexed readout
module gb_trace_buffer
    import gb_trace_pkg::*;
#(
    parameter int ADDR_W  = TRACE_ADDR_W,
    parameter int IR_W    = TRACE_IR_W,
    parameter int STATE_W = TRACE_STATE_W,
    parameter int DEPTH   = TRACE_DEPTH,
    parameter int NUM_BP  = TRACE_NUM_BP
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fetch_vld,
    input  logic [ADDR_W-1:0]               pc,
    input  logic [IR_W-1:0]                 ir,
    input  logic [STATE_W-1:0]              cp_state,
    input  logic                            arm,
    input  logic [$clog2(DEPTH)-1:0]        post_len,
    input  logic [NUM_BP-1:0]               bp_en,
    input  logic [NUM_BP*ADDR_W-1:0]        bp_addr,
    input  logic                            rd_req,
    input  logic [$clog2(DEPTH)-1:0]        rd_idx,
    output logic                            rd_vld,
    output logic [ADDR_W+IR_W+STATE_W-1:0]  rd_data,
    output logic                            rd_err,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            frozen,
    output logic                            halt_req,
    output logic [NUM_BP-1:0]               bp_hit
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = ADDR_W + IR_W + STATE_W;
    trace_state_e state, state_nxt;
    logic [NUM_BP-1:0] match;
    logic [AW-1:0]     wr_ptr, post_cnt, rd_phys;
    logic [EW-1:0]     ram_q;
    logic              cap, trig;
    for (genvar b = 0; b < NUM_BP; b++) begin : g_bp
        assign match[b] = bp_en[b] && (pc == bp_addr[b*ADDR_W +: ADDR_W]);
    end
    assign trig    = fetch_vld && |match;
    assign cap     = fetch_vld && !arm && (state == ARMED || state == POST);
    assign rd_phys = wr_ptr - count[AW-1:0] + rd_idx;
    assign frozen  = state == FROZEN;
    assign rd_data = (rd_vld && !rd_err) ? ram_q : '0;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    // The trigger entry is stored first; post_cnt only counts entries after it.
    always_comb begin
        state_nxt = state;
        if (arm)
            state_nxt = ARMED;
        else if (cap && state == ARMED && trig)
            state_nxt = (post_cnt == '0) ? FROZEN : POST;
        else if (cap && state == POST && post_cnt == AW'(1))
            state_nxt = FROZEN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
            halt_req <= 1'b0;
            bp_hit   <= '0;
            rd_vld   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_vld <= rd_req;
            rd_err <= rd_req && ({1'b0, rd_idx} >= count);
            if (arm) begin
                wr_ptr   <= '0;
                count    <= '0;
                post_cnt <= post_len;
                halt_req <= 1'b0;
                bp_hit   <= '0;
            end else begin
                if (cap) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (count != CW'(DEPTH)) count <= count + CW'(1);
                    if (state == POST) post_cnt <= post_cnt - AW'(1);
                end
                if (state == ARMED && trig) begin
                    halt_req <= 1'b1;
                    bp_hit   <= bp_hit | match;
                end
            end
        end
    end
    gb_trace_ram #(.W(EW), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (cap),
        .waddr (wr_ptr),
        .wdata ({pc, ir, cp_state}),
        .re    (rd_req),
        .raddr (rd_phys),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_gb_trace_buffer.sv
// tb_gb_trace_buffer: directed and randomized checks of gb_trace_buffer against a queue-based reference model
module tb_gb_trace_buffer;
    import gb_trace_pkg::*;
    localparam int ADDR_W = 16, IR_W = 8, STATE_W = 6, DEPTH = 64, NUM_BP = 4;
    localparam int AW = $clog2(DEPTH), EW = ADDR_W + IR_W + STATE_W;
    logic                     clk, rst, fetch_vld, arm, rd_req, rd_vld, rd_err, frozen, halt_req;
    logic [ADDR_W-1:0]        pc;
    logic [IR_W-1:0]          ir;
    logic [STATE_W-1:0]       cp_state;
    logic [AW-1:0]            post_len, rd_idx;
    logic [NUM_BP-1:0]        bp_en, bp_hit;
    logic [NUM_BP*ADDR_W-1:0] bp_addr;
    logic [EW-1:0]            rd_data;
    logic [AW:0]              count;
    int n_chk = 0, n_fail = 0;
    logic [EW-1:0]     mq[$];
    logic              m_cap, m_trig, m_frozen, m_halt, m_rd_vld, m_rd_err;
    logic [NUM_BP-1:0] m_hits;
    logic [EW-1:0]     m_rd_data;
    int                m_left;
    trace_entry_t      e;
    logic              err;
    gb_trace_buffer #(.ADDR_W(ADDR_W), .IR_W(IR_W), .STATE_W(STATE_W), .DEPTH(DEPTH), .NUM_BP(NUM_BP)) dut (
        .clk(clk), .rst(rst), .fetch_vld(fetch_vld), .pc(pc), .ir(ir), .cp_state(cp_state),
        .arm(arm), .post_len(post_len), .bp_en(bp_en), .bp_addr(bp_addr),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_vld(rd_vld), .rd_data(rd_data), .rd_err(rd_err),
        .count(count), .frozen(frozen), .halt_req(halt_req), .bp_hit(bp_hit)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    // Reference: a queue holding at most DEPTH entries, oldest first, plus trigger bookkeeping.
    task automatic model_step();
        logic [NUM_BP-1:0] hv;
        if (rst) begin
            mq.delete();
            {m_cap, m_trig, m_frozen, m_halt, m_rd_vld, m_rd_err} = '0;
            m_hits = '0; m_rd_data = '0; m_left = 0;
            return;
        end
        m_rd_vld  = rd_req;
        m_rd_err  = rd_req && (int'(rd_idx) >= mq.size());
        m_rd_data = (rd_req && !m_rd_err) ? mq[rd_idx] : '0;
        if (arm) begin
            mq.delete();
            m_cap = 1; m_trig = 0; m_frozen = 0; m_halt = 0; m_hits = '0;
            m_left = int'(post_len);
        end else if (m_cap && fetch_vld) begin
            for (int b = 0; b < NUM_BP; b++) hv[b] = bp_en[b] && (pc == bp_addr[b*ADDR_W +: ADDR_W]);
            mq.push_back({pc, ir, cp_state});
            if (mq.size() > DEPTH) void'(mq.pop_front());
            if (!m_trig) begin
                if (hv != '0) begin m_halt = 1; m_hits |= hv; m_trig = 1; end
            end else m_left--;
            if (m_trig && m_left == 0) begin m_cap = 0; m_frozen = 1; end
        end
    endtask
    task automatic tick();
        model_step();
        @(posedge clk); #1;
        check("count",    64'(count),    64'(mq.size()));
        check("frozen",   64'(frozen),   64'(m_frozen));
        check("halt_req", 64'(halt_req), 64'(m_halt));
        check("bp_hit",   64'(bp_hit),   64'(m_hits));
        check("rd_vld",   64'(rd_vld),   64'(m_rd_vld));
        check("rd_err",   64'(rd_err),   64'(m_rd_err));
        check("rd_data",  64'(rd_data),  64'(m_rd_data));
    endtask
    task automatic fetch(input logic [ADDR_W-1:0] a);
        fetch_vld = 1; pc = a; ir = IR_W'($urandom); cp_state = STATE_W'($urandom);
        tick();
        fetch_vld = 0;
    endtask
    task automatic do_arm(input logic [AW-1:0] pl);
        arm = 1; post_len = pl;
        tick();
        arm = 0;
    endtask
    task automatic do_read(input int idx, output trace_entry_t ent, output logic er);
        rd_req = 1; rd_idx = AW'(idx);
        tick();
        rd_req = 0;
        ent = rd_data; er = rd_err;
    endtask
    initial begin
        {fetch_vld, arm, rd_req} = '0;
        pc = '0; ir = '0; cp_state = '0; post_len = '0; rd_idx = '0; bp_en = '0; bp_addr = '0;
        rst = 1;
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 10; i++) fetch(ADDR_W'(16'h0080 + i));
        check("t1_count", 64'(count), 64'd0);
        check("t1_halt", 64'(halt_req), 64'd0);
        do_arm(0);
        for (int i = 0; i < 5; i++) fetch(ADDR_W'(16'h0100 + i));
        check("t2_count", 64'(count), 64'd5);
        do_read(0, e, err);
        check("t2_pc0", 64'(e.pc), 64'h0100);
        do_read(5, e, err);
        check("t2_err", 64'(err), 64'd1);
        check("t2_data", 64'(e), 64'd0);
        do_arm(0);
        for (int i = 0; i < 70; i++) fetch(ADDR_W'(i));
        check("t3_count", 64'(count), 64'd64);
        do_read(0, e, err);
        check("t3_oldest", 64'(e.pc), 64'd6);
        do_read(63, e, err);
        check("t3_newest", 64'(e.pc), 64'd69);
        bp_addr = '0; bp_addr[ADDR_W-1:0] = 16'h0150; bp_en = 4'b0001;
        do_arm(3);
        for (int a = 16'h0140; a <= 16'h0160; a++) fetch(ADDR_W'(a));
        check("t4_halt", 64'(halt_req), 64'd1);
        check("t4_hit", 64'(bp_hit), 64'b0001);
        check("t4_frozen", 64'(frozen), 64'd1);
        check("t4_count", 64'(count), 64'd20);
        do_read(19, e, err);
        check("t4_newest", 64'(e.pc), 64'h0153);
        bp_addr[ADDR_W-1:0] = 16'h0200;
        do_arm(0);
        for (int a = 16'h01F8; a <= 16'h0208; a++) fetch(ADDR_W'(a));
        check("t5_frozen", 64'(frozen), 64'd1);
        check("t5_count", 64'(count), 64'd9);
        do_read(8, e, err);
        check("t5_newest", 64'(e.pc), 64'h0200);
        arm = 1; post_len = 0;
        fetch(16'h0200);
        arm = 0;
        check("t5_rearm_count", 64'(count), 64'd0);
        check("t5_rearm_flags", 64'({halt_req, bp_hit, frozen}), 64'd0);
        bp_addr[ADDR_W-1:0] = 16'h0300;
        do_arm(10);
        for (int a = 16'h02FE; a <= 16'h0302; a++) fetch(ADDR_W'(a));
        check("t6_halt_before", 64'(halt_req), 64'd1);
        rst = 1;
        tick();
        rst = 0;
        check("t6_count", 64'(count), 64'd0);
        check("t6_halt", 64'(halt_req), 64'd0);
        for (int i = 0; i < 3; i++) fetch(16'h0300);
        check("t6_nocap", 64'(count), 64'd0);
        for (int r = 0; r < 30; r++) begin
            bp_en = NUM_BP'($urandom);
            for (int b = 0; b < NUM_BP; b++) bp_addr[b*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 31));
            do_arm(AW'($urandom));
            for (int c = 0; c < 80; c++) begin
                fetch_vld = 1'($urandom);
                pc = ADDR_W'($urandom_range(0, 31));
                ir = IR_W'($urandom);
                cp_state = STATE_W'($urandom);
                rd_req = 1'($urandom);
                rd_idx = AW'($urandom);
                arm = ($urandom_range(0, 63) == 0);
                post_len = AW'($urandom_range(0, 7));
                rst = ($urandom_range(0, 127) == 0);
                tick();
            end
            {fetch_vld, rd_req, arm, rst} = '0;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
